// File: rtl/fw_cfg_pkg.sv
// Shared state encoding, idle output levels and slot decode for the FW config-chain programmer.
package fw_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD
  } state_t;

  localparam logic CFG_LOAD_IDLE  = 1'b1;
  localparam logic RESET_NOT_IDLE = 1'b1;

  function automatic logic [3:0] slot_sel(input int unsigned idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/fw_cfg_tick.sv
// Loadable down-counter; o_tc is high while the count sits at zero, so a load of N-1 gives an N-cycle phase.
module fw_cfg_tick #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/fw_cfg_chain_shifter.sv
// Serial programmer for the DUT configuration chain: shifts a word MSB first, captures config_out
// as readback, pulses config_load low; aborts cleanly if the FW slot is deselected mid-operation.
module fw_cfg_chain_shifter
  import fw_cfg_pkg::*;
#(
  parameter int FW_INDEX    = 1,
  parameter int CFG_WIDTH   = 256,
  parameter int CLK_DIV     = 8,
  parameter int LOAD_CYCLES = 16
) (
  input  logic                 fw_pl_clk1,
  input  logic                 fw_rst_n,
  input  logic [3:0]           fw_dev_id_enable,
  input  logic                 start,
  input  logic [CFG_WIDTH-1:0] cfg_wdata,
  output logic [CFG_WIDTH-1:0] cfg_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err_not_sel,
  output logic                 err_abort,
  output logic                 fw_config_clk,
  output logic                 fw_config_in,
  output logic                 fw_config_load,
  output logic                 fw_reset_not,
  input  logic                 fw_config_out
);

  localparam int MAXDUR = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
  localparam int CW     = $clog2(MAXDUR);
  localparam int BW     = $clog2(CFG_WIDTH);
  localparam logic [CW-1:0] CDIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LOAD_M1  = CW'(LOAD_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_WIDTH - 1);

  state_t               r_state;
  logic [CFG_WIDTH-1:0] r_shreg;
  logic [CFG_WIDTH-1:0] r_rb;
  logic [BW-1:0]        r_bit_cnt;
  logic                 w_sel;
  logic                 w_tc;
  logic                 w_tick_load;
  logic [CW-1:0]        w_tick_len;

  assign w_sel        = (fw_dev_id_enable == slot_sel(FW_INDEX));
  assign fw_reset_not = RESET_NOT_IDLE;

  // Every phase is (re)armed on the terminal cycle of the previous one; only LOAD has its own length.
  assign w_tick_load = (r_state == ST_IDLE) ? (start & w_sel) : w_tc;
  assign w_tick_len  = (r_state == ST_SHIFT_HI && r_bit_cnt == LAST_BIT) ? LOAD_M1 : CDIV_M1;

  fw_cfg_tick #(.W(CW)) u_tick (
    .i_clk   (fw_pl_clk1),
    .i_rst_n (fw_rst_n),
    .i_load  (w_tick_load),
    .i_len   (w_tick_len),
    .o_tc    (w_tc)
  );

  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_rb           <= '0;
      r_bit_cnt      <= '0;
      cfg_rdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_not_sel    <= 1'b0;
      err_abort      <= 1'b0;
      fw_config_clk  <= 1'b0;
      fw_config_in   <= 1'b0;
      fw_config_load <= CFG_LOAD_IDLE;
    end else begin
      done <= 1'b0;
      if (r_state != ST_IDLE && !w_sel) begin
        r_state        <= ST_IDLE;
        r_bit_cnt      <= '0;
        busy           <= 1'b0;
        err_abort      <= 1'b1;
        fw_config_clk  <= 1'b0;
        fw_config_in   <= 1'b0;
        fw_config_load <= CFG_LOAD_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && w_sel) begin
              r_shreg        <= cfg_wdata;
              r_bit_cnt      <= '0;
              err_not_sel    <= 1'b0;
              err_abort      <= 1'b0;
              busy           <= 1'b1;
              fw_config_load <= 1'b0;
              r_state        <= ST_SETUP;
            end else if (start) begin
              err_not_sel <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (w_tc) begin
              fw_config_in <= r_shreg[CFG_WIDTH-1];
              r_state      <= ST_SHIFT_LO;
            end
          end
          ST_SHIFT_LO: begin
            if (w_tc) begin
              r_rb          <= {r_rb[CFG_WIDTH-2:0], fw_config_out};
              fw_config_clk <= 1'b1;
              r_state       <= ST_SHIFT_HI;
            end
          end
          ST_SHIFT_HI: begin
            if (w_tc) begin
              fw_config_clk <= 1'b0;
              r_shreg       <= {r_shreg[CFG_WIDTH-2:0], 1'b0};
              if (r_bit_cnt == LAST_BIT) begin
                fw_config_in <= 1'b0;
                r_state      <= ST_LOAD;
              end else begin
                // Next bit goes out on the falling edge so it is stable a full half-period before the rise.
                fw_config_in <= r_shreg[CFG_WIDTH-2];
                r_bit_cnt    <= r_bit_cnt + 1'b1;
                r_state      <= ST_SHIFT_LO;
              end
            end
          end
          ST_LOAD: begin
            if (w_tc) begin
              fw_config_load <= CFG_LOAD_IDLE;
              cfg_rdata      <= r_rb;
              done           <= 1'b1;
              busy           <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fw_cfg_chain_shifter.sv
// Randomized bench: an external 8-bit shift chain model drives config_out; readback, bit order, latency,
// error flags, abort and async reset are checked against values derived from the chain rules.
module tb_fw_cfg_chain_shifter;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int L  = 3;
  localparam int BW = 256;
  localparam int BD = 8;
  localparam int BL = 16;
  localparam logic [3:0] SEL = 4'b0010;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   en = SEL;
  logic         start = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         busy, done, e_ns, e_ab, cclk, cin, cload, rnot, cout;

  logic          b_start = 1'b0;
  logic [BW-1:0] b_wdata = '0;
  logic [BW-1:0] b_rdata;
  logic          b_busy, b_done, b_ens, b_eab, b_cclk, b_cin, b_cload, b_rnot;

  always #5 clk = ~clk;

  fw_cfg_chain_shifter #(.FW_INDEX(1), .CFG_WIDTH(W), .CLK_DIV(D), .LOAD_CYCLES(L)) dut (
    .fw_pl_clk1(clk), .fw_rst_n(rst_n), .fw_dev_id_enable(en), .start(start), .cfg_wdata(wdata),
    .cfg_rdata(rdata), .busy(busy), .done(done), .err_not_sel(e_ns), .err_abort(e_ab),
    .fw_config_clk(cclk), .fw_config_in(cin), .fw_config_load(cload), .fw_reset_not(rnot),
    .fw_config_out(cout)
  );

  fw_cfg_chain_shifter #(.FW_INDEX(1), .CFG_WIDTH(BW), .CLK_DIV(BD), .LOAD_CYCLES(BL)) dut_big (
    .fw_pl_clk1(clk), .fw_rst_n(rst_n), .fw_dev_id_enable(en), .start(b_start), .cfg_wdata(b_wdata),
    .cfg_rdata(b_rdata), .busy(b_busy), .done(b_done), .err_not_sel(b_ens), .err_abort(b_eab),
    .fw_config_clk(b_cclk), .fw_config_in(b_cin), .fw_config_load(b_cload), .fw_reset_not(b_rnot),
    .fw_config_out(1'b0)
  );

  // External pure shift chain: shifts config_in on each config_clk rise, MSB drives config_out.
  logic [W-1:0] chain = 8'h3C;
  logic [W-1:0] seen = '0;
  int           rises = 0;
  int           done_cnt = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  assign cout = chain[W-1];

  always @(posedge cclk) begin
    chain <= {chain[W-2:0], cin};
    seen  <= {seen[W-2:0], cin};
    rises = rises + 1;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [W-1:0] word, input bit noise);
    logic [W-1:0] pre;
    bit           load_bad;
    int           lat;
    int           d0;
    load_bad = 1'b0;
    lat = 0;
    @(negedge clk);
    pre   = chain;
    d0    = done_cnt;
    wdata = word;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wdata = W'($urandom);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) chk("err_clr", {e_ns, e_ab}, 2'b00);
      if (done) begin
        lat = n;
        break;
      end
      if (cload) load_bad = 1'b1;
      start = noise && (n % 7 == 3);
      if (start) wdata = W'($urandom);
    end
    start = 1'b0;
    chk("latency", lat, 1 + D * (1 + 2 * W) + L);
    chk("load_low", load_bad, 1'b0);
    chk("load_idle", cload, 1'b1);
    chk("readback", rdata, pre);
    chk("bits_out", seen, word);
    chk("chain", chain, word);
    repeat (6) @(negedge clk);
    chk("one_done", done_cnt - d0, 1);
    chk("busy_off", busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] old_rd;
    int           r0;
    int           d0;
    int           n;

    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, done, e_ns, e_ab, cclk, cin, cload, rnot}, 8'b0000_0011);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;

    prog(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) prog(W'($urandom), 1'b1);

    // Start while another slot is selected.
    @(negedge clk);
    en = 4'h1;
    start = 1'b1;
    r0 = rises;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("not_sel_err", e_ns, 1'b1);
    chk("not_sel_busy", busy, 1'b0);
    chk("not_sel_clk", rises - r0, 0);
    en = SEL;
    prog(W'($urandom), 1'b0);

    // Deselect after four bits have gone out.
    @(negedge clk);
    old_rd = rdata;
    d0 = done_cnt;
    r0 = rises;
    wdata = W'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (rises < r0 + 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", rises - r0, 4);
    en = 4'h0;
    @(negedge clk);
    chk("abort_outs", {busy, cload, cclk, e_ab}, 4'b0101);
    chk("abort_rdata", rdata, old_rd);
    en = SEL;
    repeat (40) @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);
    prog(W'($urandom), 1'b1);

    // Asynchronous reset while config_clk is high.
    @(negedge clk);
    wdata = W'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (cclk !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", cclk, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {busy, done, e_ns, e_ab, cclk, cin, cload, rnot}, 8'b0000_0011);
    chk("arst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prog(W'($urandom), 1'b0);

    // Full-size instance latency.
    @(negedge clk);
    b_wdata = {8{32'($urandom)}};
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    n = 0;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      if (b_done) begin
        n = k;
        break;
      end
    end
    chk("big_latency", n, 1 + BD * (1 + 2 * BW) + BL);
    chk("big_flags", {b_busy, b_ens, b_eab, b_cload, b_rnot, b_cclk, b_cin}, 7'b0001100);
    chk("big_rdata", b_rdata, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
